// File: rtl/demux_onehot.sv
// Registered one-hot demultiplexer: routes one word per cycle from a single
// valid/ready producer into one of N per-channel output registers.
module demux_onehot #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned N     = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [N-1:0]              in_sel,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [N-1:0][WIDTH-1:0]   out_data,
  output logic [N-1:0]              out_valid,
  input  logic [N-1:0]              out_ready,
  output logic [7:0]                err_cnt,
  output logic                      err
);

  localparam int unsigned ERR_W = 8;
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  logic [N-1:0][WIDTH-1:0] r_out_data;
  logic [N-1:0]            r_out_valid;
  logic [ERR_W-1:0]        r_err_cnt;
  logic                    r_err;

  logic [N-1:0]            w_free;
  logic                    w_legal;
  logic                    w_accept;
  logic [N-1:0]            w_load;
  logic                    w_illegal;

  // A slot is free when empty or being drained on this edge.
  assign w_free    = ~r_out_valid | out_ready;
  assign w_legal   = (in_sel != '0) && ((in_sel & (in_sel - N'(1))) == '0);
  // Illegal selects are always accepted so they can be dropped and counted.
  assign in_ready  = w_legal ? |(in_sel & w_free) : 1'b1;
  assign w_accept  = in_valid & in_ready;
  assign w_load    = {N{w_accept & w_legal}} & in_sel;
  assign w_illegal = w_accept & ~w_legal;

  // Per-channel holding registers; a load wins over a simultaneous drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_valid <= '0;
    end else begin
      for (int i = 0; i < int'(N); i++) begin
        if (w_load[i]) begin
          r_out_data[i]  <= in_data;
          r_out_valid[i] <= 1'b1;
        end else if (out_ready[i]) begin
          r_out_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Saturating drop counter and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
      r_err     <= 1'b0;
    end else if (w_illegal) begin
      r_err <= 1'b1;
      if (r_err_cnt != ERR_MAX) begin
        r_err_cnt <= r_err_cnt + ERR_W'(1);
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign err_cnt   = r_err_cnt;
  assign err       = r_err;

endmodule

// File: tb/tb_demux_onehot.sv
// Self-checking bench for demux_onehot: directed stimulus with a per-channel
// scoreboard checked by an independent output monitor.
module tb_demux_onehot;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned N     = 3;

  logic                    clk;
  logic                    rst_n;
  logic [WIDTH-1:0]        in_data;
  logic [N-1:0]            in_sel;
  logic                    in_valid;
  logic                    in_ready;
  logic [N-1:0][WIDTH-1:0] out_data;
  logic [N-1:0]            out_valid;
  logic [N-1:0]            out_ready;
  logic [7:0]              err_cnt;
  logic                    err;

  typedef struct {
    int              ch;
    logic [WIDTH-1:0] d;
  } exp_t;

  exp_t sb[$];
  int   n_vec;
  int   n_err;

  demux_onehot #(.WIDTH(WIDTH), .N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_cnt   (err_cnt),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus; in_ready is checked against the hand value and
  // accepted legal words are pushed to the scoreboard.
  task automatic drive(input logic v, input logic [N-1:0] sel, input logic [WIDTH-1:0] d,
                       input logic [N-1:0] ordy, input logic exp_rdy);
    int ones;
    int ch;
    @(posedge clk);
    #1;
    in_valid  = v;
    in_sel    = sel;
    in_data   = d;
    out_ready = ordy;
    @(negedge clk);
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    ones = 0;
    ch   = 0;
    for (int i = 0; i < int'(N); i++) begin
      if (sel[i]) begin
        ones++;
        ch = i;
      end
    end
    if (v && exp_rdy && ones == 1) sb.push_back('{ch: ch, d: d});
  endtask

  task automatic idle(input logic [N-1:0] ordy);
    drive(1'b0, '0, '0, ordy, 1'b1);
  endtask

  // Monitor: every output transfer must match the oldest word routed to that channel.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < int'(N); i++) begin
        if (out_valid[i] && out_ready[i]) begin
          int idx;
          idx = -1;
          for (int k = 0; k < sb.size(); k++) begin
            if (idx < 0 && sb[k].ch == i) idx = k;
          end
          if (idx < 0) begin
            n_vec++;
            n_err++;
            $display("FAIL out_xfer ch%0d: got unexpected word %0h expected none", i, out_data[i]);
          end else begin
            check($sformatf("out_data_ch%0d", i), 32'(out_data[i]), 32'(sb[idx].d));
            sb.delete(idx);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sel    = '0;
    in_data   = '0;
    out_ready = '0;

    // Reset state
    #2;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data", 32'(out_data[0] | out_data[1] | out_data[2]), 32'h0);
    check("rst_err_cnt", 32'(err_cnt), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    #10;
    rst_n = 1'b1;

    // First routed word lands in channel 1 only
    drive(1'b1, 3'b010, 16'hA5A5, 3'b000, 1'b1);
    idle(3'b000);
    check("t1_out_valid", 32'(out_valid), 32'h2);
    check("t1_data1", 32'(out_data[1]), 32'hA5A5);
    check("t1_data0", 32'(out_data[0]), 32'h0);
    check("t1_data2", 32'(out_data[2]), 32'h0);

    // Full channel blocks its own select only
    drive(1'b1, 3'b010, 16'hBEEF, 3'b000, 1'b0);
    drive(1'b1, 3'b001, 16'h1111, 3'b000, 1'b1);
    check("t2_out_valid", 32'(out_valid), 32'h2);
    check("t2_data1", 32'(out_data[1]), 32'hA5A5);

    // Drain and reload channel 0 on the same edge
    drive(1'b1, 3'b001, 16'h2222, 3'b001, 1'b1);
    idle(3'b000);
    check("t3_out_valid", 32'(out_valid), 32'h3);
    check("t3_data0", 32'(out_data[0]), 32'h2222);
    idle(3'b111);
    idle(3'b000);
    check("t3_drained", 32'(out_valid), 32'h0);

    // Back-to-back stream into channel 2
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, 3'b100, WIDTH'(k), 3'b100, 1'b1);
      if (k > 1) check("t4_no_bubble", 32'(out_valid), 32'h4);
    end
    idle(3'b100);
    idle(3'b000);
    check("t4_drained", 32'(out_valid), 32'h0);

    // Illegal selects are dropped and counted
    drive(1'b1, 3'b000, 16'hDEAD, 3'b000, 1'b1);
    drive(1'b1, 3'b011, 16'hBEEF, 3'b000, 1'b1);
    idle(3'b000);
    check("t5_err_cnt", 32'(err_cnt), 32'h2);
    check("t5_err", 32'(err), 32'h1);
    check("t5_out_valid", 32'(out_valid), 32'h0);
    drive(1'b0, 3'b111, 16'h0BAD, 3'b000, 1'b1);
    idle(3'b000);
    check("t5_no_valid", 32'(err_cnt), 32'h2);
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 3'b101, WIDTH'(i), 3'b000, 1'b1);
      if (i == 100) check("t5_cnt_mid", 32'(err_cnt), 32'd102);
    end
    idle(3'b000);
    check("t5_sat", 32'(err_cnt), 32'd255);
    check("t5_err_sticky", 32'(err), 32'h1);
    check("t5_out_valid2", 32'(out_valid), 32'h0);

    // Asynchronous reset while data is held
    drive(1'b1, 3'b001, 16'hC0C0, 3'b000, 1'b1);
    drive(1'b1, 3'b100, 16'hC2C2, 3'b000, 1'b1);
    idle(3'b000);
    check("t6_held", 32'(out_valid), 32'h5);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_out_valid", 32'(out_valid), 32'h0);
    check("t6_out_data", 32'(out_data[0] | out_data[1] | out_data[2]), 32'h0);
    check("t6_err_cnt", 32'(err_cnt), 32'h0);
    check("t6_err", 32'(err), 32'h0);
    check("t6_in_ready", 32'(in_ready), 32'h1);
    sb.delete();
    #13;
    rst_n = 1'b1;

    // Operation resumes after reset
    drive(1'b1, 3'b010, 16'h5A5A, 3'b000, 1'b1);
    idle(3'b010);
    idle(3'b000);
    check("t7_out_valid", 32'(out_valid), 32'h0);
    check("sb_empty", 32'(sb.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
